// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter.
// Read-owner encoding and datapath widths.
package unified_mem_arbiter_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } own_e;

endpackage

// File: rtl/unified_mem_arbiter_prio_pick.sv
// Two-requester priority picker.
// req_hi normally wins; force_low hands one conflict to req_lo.
module arb_prio_pick (
  input  logic req_hi,
  input  logic req_lo,
  input  logic force_low,
  output logic gnt_hi,
  output logic gnt_lo
);

  // Low side wins when alone or when forced; high takes the rest.
  always_comb begin
    gnt_lo = req_lo & (force_low | ~req_hi);
    gnt_hi = req_hi & ~gnt_lo;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Fetch/data arbiter for one single-port word RAM.
// Data has priority; fetch wins after MAX_WAIT lost conflicts.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int AW       = 7,
  parameter int MAX_WAIT = 3,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_req,
  input  logic [XLEN-1:0]   i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [XLEN-1:0]   i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic [STRB_W-1:0] mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int WW =
    (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam bit GUARD_ON = (MAX_WAIT != 0);

  logic [WW-1:0] wait_cnt;
  own_e          rd_own;
  own_e          rd_own_nx;
  logic          pick_i;
  logic          pick_d;
  logic          force_i;
  logic          conflict;

  assign conflict = i_req & d_req;
  assign force_i  = GUARD_ON && (wait_cnt == WAIT_MAX);

  arb_prio_pick u_pick (
    .req_hi    (d_req),
    .req_lo    (i_req),
    .force_low (force_i),
    .gnt_hi    (pick_d),
    .gnt_lo    (pick_i)
  );

  // Grants and stalls are held off while reset is asserted.
  always_comb begin
    i_gnt     = pick_i & rstn;
    d_gnt     = pick_d & rstn;
    stall_if  = i_req & ~i_gnt & rstn;
    stall_mem = d_req & ~d_gnt & rstn;
  end

  // Steer the winner onto the RAM and note who owns the read.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    rd_own_nx = OWN_NONE;
    if (i_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = i_addr[AW+1:2];
      mem_wdata = d_wdata;
      rd_own_nx = OWN_I;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = d_addr[AW+1:2];
      mem_wdata = d_wdata;
      mem_we    = d_we ? d_wstrb : '0;
      rd_own_nx = d_we ? OWN_NONE : OWN_D;
    end
  end

  // Read owner for the response one cycle after grant.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_own <= OWN_NONE;
    else       rd_own <= rd_own_nx;
  end

  // Count consecutive fetch losses, saturating at MAX_WAIT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Saturating count of cycles where both sides request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  // Route RAM data to the owning port only.
  always_comb begin
    i_rvalid = (rd_own == OWN_I);
    d_rvalid = (rd_own == OWN_D);
    i_rdata  = i_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: two configurations,
// directed and random stimulus against a behavioural model.
module tb_unified_mem_arbiter;

  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;

  logic [1:0]    i_gnt;
  logic [1:0]    i_rvalid;
  logic [1:0]    d_gnt;
  logic [1:0]    d_rvalid;
  logic [1:0]    stall_if;
  logic [1:0]    stall_mem;
  logic [1:0]    mem_en;
  logic [31:0]   i_rdata   [2];
  logic [31:0]   d_rdata   [2];
  logic [31:0]   mem_wdata [2];
  logic [31:0]   mem_rdata [2];
  logic [3:0]    mem_we    [2];
  logic [AW-1:0] mem_addr  [2];
  logic [15:0]   cnt_a;
  logic [3:0]    cnt_b;

  logic [31:0] seed;
  logic [31:0] ram [2][DEPTH];

  int checks = 0;
  int errors = 0;

  unified_mem_arbiter #(
    .AW(AW), .MAX_WAIT(3), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr),
    .i_gnt(i_gnt[0]), .i_rvalid(i_rvalid[0]),
    .i_rdata(i_rdata[0]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]),
    .d_rdata(d_rdata[0]),
    .stall_if(stall_if[0]), .stall_mem(stall_mem[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]),
    .conflict_cnt(cnt_a)
  );

  unified_mem_arbiter #(
    .AW(AW), .MAX_WAIT(0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr),
    .i_gnt(i_gnt[1]), .i_rvalid(i_rvalid[1]),
    .i_rdata(i_rdata[1]),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]),
    .d_rdata(d_rdata[1]),
    .stall_if(stall_if[1]), .stall_mem(stall_mem[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]),
    .conflict_cnt(cnt_b)
  );

  function automatic logic [31:0] init_word(int j);
    return (32'(j) * 32'h9E37_79B1) ^ seed;
  endfunction

  // One RAM per DUT; reloaded with known contents in reset.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        mem_rdata[k] <= '0;
        for (int j = 0; j < DEPTH; j++)
          ram[k][j] <= init_word(j);
      end else if (mem_en[k]) begin
        if (mem_we[k] == 4'b0) begin
          mem_rdata[k] <= ram[k][mem_addr[k]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (mem_we[k][b])
              ram[k][mem_addr[k]][8*b +: 8]
                <= mem_wdata[k][8*b +: 8];
        end
      end
    end
  end

  // Reference model state: 0 none, 1 fetch, 2 data.
  logic [31:0] rmem [2][DEPTH];
  int          losses [2];
  int          ccnt   [2];
  int          pown   [2];
  logic [31:0] pdat   [2];
  bit          giw    [2];
  bit          gdw    [2];
  bit          in_rst;

  function automatic int mw(int c);
    return (c == 0) ? 3 : 0;
  endfunction

  function automatic int cmax(int c);
    return (c == 0) ? 65535 : 15;
  endfunction

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic check_cfg(int c);
    bit          iw;
    bit          dw;
    bit          any;
    int          ep;
    logic [31:0] wa;
    logic [31:0] ew;
    logic [31:0] cobs;
    string       p;
    p = (c == 0) ? "mw3" : "mw0";
    if (in_rst) begin
      iw = 0;
      dw = 0;
    end else if (i_req && d_req) begin
      iw = (mw(c) > 0) && (losses[c] == mw(c));
      dw = !iw;
    end else begin
      iw = i_req;
      dw = d_req;
    end
    any = iw || dw;
    wa  = iw ? i_addr : d_addr;
    ew  = any ? 32'(wa[AW+1:2]) : 32'd0;
    ep  = in_rst ? 0 : pown[c];
    cobs = (c == 0) ? 32'(cnt_a) : 32'(cnt_b);
    giw[c] = iw;
    gdw[c] = dw;
    chk({p, ".i_gnt"}, 32'(i_gnt[c]), 32'(iw));
    chk({p, ".d_gnt"}, 32'(d_gnt[c]), 32'(dw));
    chk({p, ".mem_en"}, 32'(mem_en[c]), 32'(any));
    chk({p, ".mem_addr"}, 32'(mem_addr[c]), ew);
    chk({p, ".mem_we"}, 32'(mem_we[c]),
        (dw && d_we) ? 32'(d_wstrb) : 32'd0);
    chk({p, ".mem_wdata"}, mem_wdata[c],
        any ? d_wdata : 32'd0);
    chk({p, ".stall_if"}, 32'(stall_if[c]),
        32'(i_req && !iw && !in_rst));
    chk({p, ".stall_mem"}, 32'(stall_mem[c]),
        32'(d_req && !dw && !in_rst));
    chk({p, ".i_rvalid"}, 32'(i_rvalid[c]),
        32'(ep == 1));
    chk({p, ".d_rvalid"}, 32'(d_rvalid[c]),
        32'(ep == 2));
    chk({p, ".i_rdata"}, i_rdata[c],
        (ep == 1) ? pdat[c] : 32'd0);
    chk({p, ".d_rdata"}, d_rdata[c],
        (ep == 2) ? pdat[c] : 32'd0);
    chk({p, ".conflict_cnt"}, cobs,
        in_rst ? 32'd0 : 32'(ccnt[c]));
  endtask

  task automatic update_cfg(int c);
    int w;
    if (in_rst) begin
      losses[c] = 0;
      ccnt[c]   = 0;
      pown[c]   = 0;
      pdat[c]   = '0;
      for (int j = 0; j < DEPTH; j++)
        rmem[c][j] = init_word(j);
      return;
    end
    if (i_req && d_req && ccnt[c] < cmax(c))
      ccnt[c]++;
    if (!i_req || giw[c]) losses[c] = 0;
    else if (losses[c] < mw(c)) losses[c]++;
    pown[c] = 0;
    pdat[c] = '0;
    if (giw[c]) begin
      w = int'(i_addr[AW+1:2]);
      pown[c] = 1;
      pdat[c] = rmem[c][w];
    end else if (gdw[c]) begin
      w = int'(d_addr[AW+1:2]);
      if (d_we) begin
        for (int b = 0; b < 4; b++)
          if (d_wstrb[b])
            rmem[c][w][8*b +: 8] = d_wdata[8*b +: 8];
      end else begin
        pown[c] = 2;
        pdat[c] = rmem[c][w];
      end
    end
  endtask

  task automatic set_in(bit ir, logic [31:0] ia,
                        bit dr, bit we,
                        logic [31:0] da,
                        logic [31:0] wd,
                        logic [3:0] st);
    i_req   = ir;
    i_addr  = ia;
    d_req   = dr;
    d_we    = we;
    d_addr  = da;
    d_wdata = wd;
    d_wstrb = st;
  endtask

  task automatic step();
    #1;
    check_cfg(0);
    check_cfg(1);
    update_cfg(0);
    update_cfg(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rnd_in(bit force_both);
    bit ir;
    bit dr;
    ir = force_both || ($urandom_range(0, 3) != 0);
    dr = force_both || ($urandom_range(0, 3) != 0);
    set_in(ir, $urandom, dr, 1'($urandom),
           $urandom, $urandom, 4'($urandom));
  endtask

  logic [7:0] ipat;

  initial begin
    seed   = $urandom;
    rstn   = 1'b0;
    in_rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      losses[c] = 0;
      ccnt[c]   = 0;
      pown[c]   = 0;
      pdat[c]   = '0;
    end
    set_in(1, 32'h10, 1, 0, 32'h20, 32'h0, 4'h0);
    @(negedge clk);
    step();
    step();

    rstn   = 1'b1;
    in_rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();

    set_in(1, 32'h0000_0010, 0, 0, 0, 0, 0);
    repeat (3) step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();

    set_in(0, 0, 1, 1, 32'h24,
           32'hAABB_CCDD, 4'b0011);
    step();
    set_in(0, 0, 1, 0, 32'h24, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("wr_rd.low_half",
        32'(d_rdata[0][15:0]), 32'h0000_CCDD);
    step();

    ipat = '0;
    for (int n = 0; n < 8; n++) begin
      set_in(1, $urandom, 1, 0, $urandom, 0, 0);
      #1;
      ipat[n] = i_gnt[0];
      step();
    end
    chk("conflict.pattern", 32'(ipat), 32'h88);
    chk("conflict.cnt8", 32'(cnt_a), 32'd8);

    for (int n = 0; n < 300; n++) begin
      rnd_in(1'b0);
      step();
    end

    set_in(0, 0, 1, 0, 32'h40, 0, 0);
    #1;
    chk("rst_mid.d_gnt", 32'(d_gnt[0]), 32'd1);
    #1;
    rstn   = 1'b0;
    in_rst = 1'b1;
    step();
    rstn   = 1'b1;
    in_rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    step();

    for (int n = 0; n < 20; n++) begin
      rnd_in(1'b1);
      step();
    end
    #1;
    chk("sat.cnt_b", 32'(cnt_b), 32'd15);
    chk("sat.cnt_a", 32'(cnt_a), 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
